// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Summary  : Receive buffer behind the UART receiver core. Stores each
//            ack/err-qualified character with its error tag in a circular
//            FIFO and presents the head entry show-ahead to the bus side.
//            Reports fill count, threshold hit and sticky overflow.
//            Optional idle timeout enabled by macro UART_RX_FIFO_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_BITS      = 8,
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DATA_BITS-1:0]  rx_data,
    input  logic                  rx_ack,
    input  logic                  rx_err,
    input  logic                  rx_busy,
    input  logic                  rd_en,
    output logic [DATA_BITS-1:0]  rd_data,
    output logic                  rd_err,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    input  logic [ADDR_WIDTH:0]   level,
    output logic                  level_hit,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  timeout
);

    localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    // Storage: MSB of each entry is the error tag
    logic [DATA_BITS:0]    mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,     count_d;
    logic                  empty_q,     empty_d;
    logic                  full_q,      full_d;
    logic                  level_hit_q, level_hit_d;
    logic                  overflow_q,  overflow_d;

    logic                  w_wr_ev;
    logic                  w_rd_ev;
    logic                  w_wr_acc;
    logic                  w_drop;

    // Event decode: a write while full is only accepted if a pop frees a slot
    always_comb begin
        w_wr_ev  = rx_ack | rx_err;
        w_rd_ev  = rd_en & ~empty_q;
        w_wr_acc = w_wr_ev & (~full_q | w_rd_ev);
        w_drop   = w_wr_ev & full_q & ~w_rd_ev;
    end

    // Next-state for pointers, count, flags; flags derive from next count
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;

        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_ev) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_wr_acc && !w_rd_ev) begin
            count_d = count_q + 1'b1;
        end else if (!w_wr_acc && w_rd_ev) begin
            count_d = count_q - 1'b1;
        end

        // A new drop outranks a simultaneous clear request
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end

        empty_d     = (count_d == '0);
        full_d      = (count_d == c_FULL_COUNT);
        level_hit_d = (level != '0) && (count_d >= level);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            level_hit_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            level_hit_q <= level_hit_d;
            overflow_q  <= overflow_d;
        end
    end

    // Entry storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && !clr && w_wr_acc) begin
            mem_q[wr_ptr_q] <= {rx_err, rx_data};
        end
    end

    assign rd_data   = mem_q[rd_ptr_q][DATA_BITS-1:0];
    assign rd_err    = mem_q[rd_ptr_q][DATA_BITS];
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign level_hit = level_hit_q;
    assign overflow  = overflow_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;

    // Idle counter saturates at its last value and raises the sticky flag
    always_comb begin
        idle_d    = idle_q;
        timeout_d = timeout_q;
        if (clr) begin
            idle_d    = '0;
            timeout_d = 1'b0;
        end else if (w_wr_ev || w_rd_ev) begin
            idle_d    = '0;
            timeout_d = 1'b0;
        end else if (rx_busy || empty_q) begin
            idle_d    = '0;
        end else if (idle_q == c_TO_LAST) begin
            timeout_d = 1'b1;
        end else begin
            idle_d    = idle_q + 1'b1;
        end
    end

    // Timeout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    // Receiver busy only qualifies the timeout, which is compiled out here
    logic w_unused_busy;
    assign w_unused_busy = rx_busy;
    assign timeout       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Summary  : Scoreboard bench for uart_rx_fifo. Accepted characters are
//            queued as they are written; a negedge monitor pops and compares
//            the head whenever the DUT performs a read. Flags are checked
//            against hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_ack = 1'b0;
    logic       rx_err = 1'b0;
    logic       rx_busy = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic [4:0] level = '0;
    logic       level_hit;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic       timeout;

    int tests  = 0;
    int failed = 0;
    logic [8:0] sb[$];

    uart_rx_fifo #(
        .DATA_BITS(8), .DEPTH(16), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .rx_data(rx_data), .rx_ack(rx_ack),
        .rx_err(rx_err), .rx_busy(rx_busy), .rd_en(rd_en), .rd_data(rd_data),
        .rd_err(rd_err), .empty(empty), .full(full), .count(count),
        .level(level), .level_hit(level_hit), .overflow(overflow),
        .ovf_clr(ovf_clr), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every real pop must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && rd_en && !empty) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", {23'd0, rd_err, rd_data}, 32'h1ff);
            end else begin
                chk("pop_data", {23'd0, rd_err, rd_data}, {23'd0, sb.pop_front()});
            end
        end
    end

    // One clock of stimulus; push marks a character the FIFO must keep
    task automatic io(input logic a, input logic e, input logic [7:0] d,
                      input logic r, input logic push);
        rx_ack  = a;
        rx_err  = e;
        rx_data = d;
        rd_en   = r;
        if (push) sb.push_back({e, d});
        @(posedge clk); #1;
        rx_ack = 1'b0;
        rx_err = 1'b0;
        rd_en  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        io(1'b1, 1'b0, d, 1'b0, 1'b1);
    endtask

    task automatic pop();
        io(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle(2);
        rst = 1'b0;
        idle(1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level_hit", level_hit, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);

        // Basic ordering
        wr(8'h41); wr(8'h42); wr(8'h43);
        chk("t1_count", count, 3);
        chk("t1_empty", empty, 0);
        chk("t1_head", rd_data, 8'h41);
        chk("t1_head_err", rd_err, 0);
        pop(); pop(); pop();
        chk("t1_empty_after", empty, 1);
        chk("t1_count_after", count, 0);
        pop();
        chk("rd_empty_ignored", count, 0);

        // Error tagging, including ack and err together
        io(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
        wr(8'h66);
        io(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
        chk("t2_head", rd_data, 8'h55);
        chk("t2_head_err", rd_err, 1);
        pop();
        chk("t2_head2_err", rd_err, 0);
        pop(); pop();
        chk("t2_empty", empty, 1);

        // Fill, overflow drop, drain
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("t3_full", full, 1);
        chk("t3_count", count, 16);
        chk("t3_ovf_pre", overflow, 0);
        io(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        chk("t3_ovf", overflow, 1);
        chk("t3_count_drop", count, 16);
        for (int i = 0; i < 16; i++) pop();
        chk("t3_drained", empty, 1);
        chk("t3_ovf_sticky", overflow, 1);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        chk("t3_ovf_clr", overflow, 0);

        // Write and read together while full
        for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
        io(1'b1, 1'b0, 8'hAA, 1'b1, 1'b1);
        chk("t4_count", count, 16);
        chk("t4_ovf", overflow, 0);
        chk("t4_full", full, 1);
        for (int i = 0; i < 15; i++) pop();
        chk("t4_head", rd_data, 8'hAA);
        pop();
        chk("t4_empty", empty, 1);

        // Threshold
        level = 5'd4;
        wr(8'h01); wr(8'h02); wr(8'h03);
        chk("t5_lh_3", level_hit, 0);
        wr(8'h04);
        chk("t5_lh_4", level_hit, 1);
        chk("t5_count_4", count, 4);
        pop();
        chk("t5_lh_pop", level_hit, 0);
        level = 5'd0;
        for (int i = 0; i < 13; i++) wr(8'h80 + 8'(i));
        chk("t5_lh_zero_full", level_hit, 0);
        chk("t5_full", full, 1);
        for (int i = 0; i < 16; i++) pop();
        chk("t5_empty", empty, 1);

        // Flush with contents and overflow pending
        for (int i = 0; i < 16; i++) wr(8'hC0 + 8'(i));
        io(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) pop();
        chk("t6_count5", count, 5);
        chk("t6_ovf_set", overflow, 1);
        clr = 1'b1; idle(1); clr = 1'b0;
        sb.delete();
        chk("t6_clr_count", count, 0);
        chk("t6_clr_empty", empty, 1);
        chk("t6_clr_ovf", overflow, 0);

        // Write and read together while empty: write only
        io(1'b1, 1'b0, 8'h5A, 1'b1, 1'b1);
        chk("t7_count", count, 1);
        chk("t7_head", rd_data, 8'h5A);
        pop();
        chk("t7_empty", empty, 1);

        // Drop and ovf_clr in the same cycle: set wins
        for (int i = 0; i < 16; i++) wr(8'(i));
        ovf_clr = 1'b1;
        io(1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
        ovf_clr = 1'b0;
        chk("t8_ovf_set_wins", overflow, 1);
        clr = 1'b1; idle(1); clr = 1'b0;
        sb.delete();
        chk("t8_clr_empty", empty, 1);

        // Idle timeout with one entry held
        wr(8'h33);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        idle(9);
        chk("t9_to_early", timeout, 0);
        idle(1);
        chk("t9_to_set", timeout, 1);
        idle(3);
        chk("t9_to_sticky", timeout, 1);
        pop();
        chk("t9_to_clr", timeout, 0);
`else
        idle(12);
        chk("t9_to_off", timeout, 0);
        pop();
`endif
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART receiver core. It captures each character reported by the receiver's one-cycle ack/err pulses into a circular FIFO, tagging each entry with its error status. It presents the head entry to the bus-side register interface with a show-ahead read handshake. It also reports fill level, a programmable threshold hit, and sticky overflow.

Parameters:
DATA_BITS, 8, width of one received character (matches receiver maximum data length)
DEPTH, 16, number of FIFO entries; must be a power of two, at least 2
ADDR_WIDTH, 4, log2(DEPTH)
TIMEOUT_CYCLES, 4000, idle clk cycles before timeout (used only with the optional feature)

Ports:
clk  in  1  main clock
rst  in  1  synchronous reset, active-high
clr  in  1  synchronous flush: empties FIFO, clears overflow and timeout
rx_data  in  DATA_BITS  character from receiver, valid in the cycle rx_ack or rx_err is high
rx_ack  in  1  one-cycle pulse: character received correctly
rx_err  in  1  one-cycle pulse: character received with framing/parity error
rx_busy  in  1  receiver busy flag (timeout qualifier)
rd_en  in  1  pop request from bus side
rd_data  out  DATA_BITS  head entry data, valid while empty=0
rd_err  out  1  head entry error tag, valid while empty=0
empty  out  1  FIFO holds zero entries
full  out  1  FIFO holds DEPTH entries
count  out  ADDR_WIDTH+1  current number of entries, 0..DEPTH
level  in  ADDR_WIDTH+1  threshold for level_hit
level_hit  out  1  registered: count >= level and level != 0
overflow  out  1  sticky: a character was dropped because the FIFO was full
ovf_clr  in  1  clears overflow
timeout  out  1  idle timeout flag (optional feature; 0 when compiled out)

Behaviour:
- Reset and clr values: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, level_hit=0, overflow=0, timeout=0. rd_data/rd_err are don't-care while empty. rst has priority over clr; clr has priority over all other events in the same cycle.
- Write event: rx_ack|rx_err. The FIFO stores {rx_err, rx_data} at wr_ptr. If rx_ack and rx_err are both high, the entry is stored with err=1.
- Read event: rd_en && !empty. It advances rd_ptr. rd_en while empty is ignored; no state change.
- Show-ahead: rd_data/rd_err always reflect the entry at rd_ptr. After a pop, the next entry is visible in the following cycle.
- Latency: a write into an empty FIFO causes empty to deassert and count to update on the next clk edge. Memory contents are readable in that same cycle.
- Pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0. count is a separate registered counter:
  - +1 on write only
  - -1 on read only
  - unchanged on simultaneous read and write
- Full boundary:
  - A write while full with no read drops the character and sets overflow=1 on the next edge. FIFO contents are unchanged.
  - A write while full with a simultaneous read is accepted. count stays DEPTH and overflow is unaffected.
- Empty boundary: a simultaneous write and rd_en while empty performs the write only. The read is ignored.
- overflow stays set until ovf_clr, clr, or rst. If ovf_clr and a new drop occur in the same cycle, overflow is 1 (set wins).
- full = (count==DEPTH) and empty = (count==0). Both are registered and consistent with count every cycle.
- level_hit is computed from the next-state count, so it updates in the same cycle as count.
- Reset mid-character: the FIFO ignores rx_busy for storage. Only ack/err pulses write.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - An idle counter (width fits TIMEOUT_CYCLES) increments each cycle while empty=0, rx_busy=0, no write, and no read occur.
  - The counter resets to 0 on any write, any read, rx_busy=1, empty=1, clr, or rst.
  - When the counter reaches TIMEOUT_CYCLES-1, timeout sets to 1. It stays sticky until the next read, write, clr, or rst.
- Undefined: no counter logic; timeout is tied to 0.

Test Plan:
- Reset, then rx_ack pulses with 0x41, 0x42, 0x43 -> count=3, empty=0, rd_data=0x41 rd_err=0; three rd_en pops return 0x41, 0x42, 0x43 in order, then empty=1, count=0.
- rx_err pulse with rx_data=0x55, then rx_ack with 0x66 -> head 0x55 rd_err=1; after pop, head 0x66 rd_err=0.
- Write 16 characters 0x00..0x0F, then a 17th (0xFF) -> full=1, count=16, overflow=1; popping all 16 yields 0x00..0x0F and 0xFF is never seen. ovf_clr then gives overflow=0.
- With the FIFO full, assert rx_ack (0xAA) and rd_en in the same cycle -> count stays 16, overflow=0; after 15 further pops the head is 0xAA.
- level=4: write 3 -> level_hit=0; write a 4th -> level_hit=1 on the same edge count becomes 4; pop 1 -> level_hit=0. With level=0, level_hit stays 0 at any count.
- clr asserted with count=5 and overflow=1 -> next cycle count=0, empty=1, overflow=0. With the macro defined, TIMEOUT_CYCLES=10, one entry and rx_busy=0 -> timeout=1 exactly 10 cycles after the write, and it clears on the pop.
